// File: rtl/adv_drc_axi_pusher_mo.sv
// DMA write pusher: round-robin arbitration of per-path descriptor/data FIFOs onto one AXI4
// write master, with decoupled AW/W channels, bounded outstanding bursts and per-path B status.
module adv_drc_axi_pusher_mo #(
  parameter int p_paths     = 2,
  parameter int p_id_bits   = 4,
  parameter int p_data_bits = 128,
  parameter int p_max_out   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [p_paths*40-1:0]          paths_burst_in,
  input  logic [p_paths-1:0]             paths_burst_empty,
  output logic [p_paths-1:0]             paths_burst_rd,
  input  logic [p_paths*p_data_bits-1:0] paths_data_in,
  input  logic [p_paths-1:0]             paths_data_empty,
  output logic [p_paths-1:0]             paths_data_rd,
  output logic [31:0]                    awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [3:0]                     awcache,
  output logic [2:0]                     awproto,
  output logic [p_id_bits-1:0]           awid,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [p_data_bits-1:0]         wdata,
  output logic [p_data_bits/8-1:0]       wstrb,
  output logic                           wlast,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [p_id_bits-1:0]           bid,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready,
  output logic [p_paths-1:0]             o_done,
  output logic [p_paths-1:0]             o_err,
  input  logic [p_paths-1:0]             i_err_clr,
  output logic [$clog2(p_max_out):0]     o_outstanding
);
  localparam int lp_pw = (p_paths > 1) ? $clog2(p_paths) : 1;
  localparam int lp_qw = (p_max_out > 1) ? $clog2(p_max_out) : 1;
  localparam int lp_ow = $clog2(p_max_out) + 1;

  typedef enum logic {AW_IDLE, AW_ADDR} aw_state_t;
  typedef enum logic {W_IDLE, W_BURST} w_state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready; once valid is
  // raised, the payload is held stable and valid stays high until that transfer.

  logic [39:0]            w_desc [p_paths];
  logic [p_data_bits-1:0] w_data [p_paths];
  for (genvar g = 0; g < p_paths; g++) begin : g_unpack
    assign w_desc[g] = paths_burst_in[g*40 +: 40];
    assign w_data[g] = paths_data_in[g*p_data_bits +: p_data_bits];
  end

  aw_state_t        r_aw_state, w_aw_next;
  logic [lp_pw-1:0] r_rr_ptr, r_aw_path, w_grant, w_idx;
  logic [31:0]      r_awaddr;
  logic [7:0]       r_awlen;
  logic             w_grant_valid, w_aw_start, w_aw_hs;
  logic [lp_ow-1:0] r_out;
  logic [lp_pw+7:0] r_q_mem [p_max_out];
  logic [lp_qw-1:0] r_q_wr, r_q_rd;
  logic [lp_ow-1:0] r_q_cnt;
  logic             w_q_full;
  w_state_t         r_w_state, w_w_next;
  logic [lp_pw-1:0] r_w_path;
  logic [7:0]       r_w_cnt;
  logic             w_w_start, w_wvalid, w_w_hs;
  logic             r_bready, w_b_hs;
  logic [p_paths-1:0] w_b_mask, r_done, r_err;

  // First non-empty path strictly after the pointer, wrapping around.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    for (int k = 1; k <= p_paths; k++) begin
      w_idx = lp_pw'((int'(r_rr_ptr) + k) % p_paths);
      if (!w_grant_valid && !paths_burst_empty[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_idx;
      end
    end
  end

  assign w_q_full   = (r_q_cnt == lp_ow'(p_max_out));
  assign w_aw_start = !i_rst && (r_aw_state == AW_IDLE) && w_grant_valid &&
                      (r_out < lp_ow'(p_max_out)) && !w_q_full;
  assign w_aw_hs    = (r_aw_state == AW_ADDR) && awready;

  always_comb begin
    w_aw_next      = r_aw_state;
    paths_burst_rd = '0;
    case (r_aw_state)
      AW_IDLE: if (w_aw_start) begin
        w_aw_next               = AW_ADDR;
        paths_burst_rd[w_grant] = 1'b1;
      end
      AW_ADDR: if (awready) w_aw_next = AW_IDLE;
      default: w_aw_next = AW_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_state <= AW_IDLE;
      r_rr_ptr   <= lp_pw'(p_paths - 1);
      r_aw_path  <= '0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
    end else begin
      r_aw_state <= w_aw_next;
      if (w_aw_start) begin
        r_aw_path <= w_grant;
        r_awaddr  <= w_desc[w_grant][39:8];
        r_awlen   <= w_desc[w_grant][7:0] - 8'd1;
      end
      if (w_aw_hs) r_rr_ptr <= r_aw_path;
    end
  end

  // Command queue hands {path, awlen} from the AW side to the W side.
  function automatic logic [lp_qw-1:0] f_q_next(input logic [lp_qw-1:0] ptr);
    return (ptr == lp_qw'(p_max_out - 1)) ? '0 : ptr + lp_qw'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_aw_hs) r_q_mem[r_q_wr] <= {r_aw_path, r_awlen};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_aw_hs) r_q_wr <= f_q_next(r_q_wr);
      if (w_w_start) r_q_rd <= f_q_next(r_q_rd);
      case ({w_aw_hs, w_w_start})
        2'b10:   r_q_cnt <= r_q_cnt + lp_ow'(1);
        2'b01:   r_q_cnt <= r_q_cnt - lp_ow'(1);
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  assign w_w_start = (r_w_state == W_IDLE) && (r_q_cnt != '0);
  assign w_wvalid  = !i_rst && (r_w_state == W_BURST) && !paths_data_empty[r_w_path];
  assign w_w_hs    = w_wvalid && wready;

  always_comb begin
    w_w_next      = r_w_state;
    paths_data_rd = '0;
    case (r_w_state)
      W_IDLE:  if (w_w_start) w_w_next = W_BURST;
      W_BURST: if (w_w_hs) begin
        paths_data_rd[r_w_path] = 1'b1;
        if (r_w_cnt == 8'd0) w_w_next = W_IDLE;
      end
      default: w_w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w_state <= W_IDLE;
      r_w_path  <= '0;
      r_w_cnt   <= '0;
    end else begin
      r_w_state <= w_w_next;
      if (w_w_start) {r_w_path, r_w_cnt} <= r_q_mem[r_q_rd];
      else if (w_w_hs) r_w_cnt <= r_w_cnt - 8'd1;
    end
  end

  // Out-of-range bids match no mask bit, so they only retire an outstanding burst.
  always_comb begin
    w_b_mask = '0;
    for (int p = 0; p < p_paths; p++) w_b_mask[p] = (bid == p_id_bits'(p));
  end
  assign w_b_hs = bvalid && r_bready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bready <= 1'b0;
      r_done   <= '0;
      r_err    <= '0;
      r_out    <= '0;
    end else begin
      r_bready <= 1'b1;
      r_done   <= w_b_hs ? w_b_mask : '0;
      r_err    <= (r_err & ~i_err_clr) | ((w_b_hs && (bresp != 2'b00)) ? w_b_mask : '0);
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_out <= r_out + lp_ow'(1);
        2'b01:   r_out <= r_out - lp_ow'(1);
        default: r_out <= r_out;
      endcase
    end
  end

  assign awaddr        = r_awaddr;
  assign awlen         = r_awlen;
  assign awsize        = 3'($clog2(p_data_bits / 8));
  assign awburst       = 2'b01;
  assign awcache       = 4'b0011;
  assign awproto       = 3'b000;
  assign awid          = p_id_bits'(r_aw_path);
  assign awvalid       = (r_aw_state == AW_ADDR);
  assign wdata         = w_data[r_w_path];
  assign wstrb         = '1;
  assign wlast         = w_wvalid && (r_w_cnt == 8'd0);
  assign wvalid        = w_wvalid;
  assign bready        = r_bready;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_outstanding = r_out;
endmodule

// File: tb/tb_adv_drc_axi_pusher_mo.sv
// Directed bench for adv_drc_axi_pusher_mo: FIFO models per path, AW/W/B scoreboard queues,
// hand-written expected bursts and status values.
module tb_adv_drc_axi_pusher_mo;
  localparam int P  = 2;
  localparam int DB = 32;
  localparam int MO = 4;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [P*40-1:0] paths_burst_in = '0;
  logic [P-1:0]    paths_burst_empty = '1;
  logic [P-1:0]    paths_burst_rd;
  logic [P*DB-1:0] paths_data_in = '0;
  logic [P-1:0]    paths_data_empty = '1;
  logic [P-1:0]    paths_data_rd;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [3:0]      awcache;
  logic [2:0]      awproto;
  logic [3:0]      awid;
  logic            awvalid;
  logic            awready = 1'b1;
  logic [DB-1:0]   wdata;
  logic [DB/8-1:0] wstrb;
  logic            wlast, wvalid;
  logic            wready = 1'b1;
  logic [3:0]      bid = '0;
  logic [1:0]      bresp = '0;
  logic            bvalid = 1'b0;
  logic            bready;
  logic [P-1:0]    o_done, o_err;
  logic [P-1:0]    i_err_clr = '0;
  logic [2:0]      o_outstanding;

  adv_drc_axi_pusher_mo #(.p_paths(P), .p_id_bits(4), .p_data_bits(DB), .p_max_out(MO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .paths_burst_in(paths_burst_in), .paths_burst_empty(paths_burst_empty),
    .paths_burst_rd(paths_burst_rd),
    .paths_data_in(paths_data_in), .paths_data_empty(paths_data_empty),
    .paths_data_rd(paths_data_rd),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
    .awproto(awproto), .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .o_done(o_done), .o_err(o_err), .i_err_clr(i_err_clr), .o_outstanding(o_outstanding)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- models and scoreboard state ----------------
  logic [39:0] desc_q [P][$];
  logic [31:0] data_q [P][$];
  logic [43:0] exp_aw_q [$];
  logic [36:0] exp_w_q [$];
  logic [5:0]  b_q [$];
  logic [43:0] m_ae;
  logic [36:0] m_we;
  logic [P-1:0] stall = '0;
  bit  auto_b = 1'b0;
  bit  b_en = 1'b1;
  int  n_checks = 0;
  int  n_errors = 0;
  int  aw_cnt = 0;
  int  w_cnt = 0;
  int  data_pops = 0;
  int  seq = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    for (int p = 0; p < P; p++) begin
      paths_burst_empty[p]    = (desc_q[p].size() == 0);
      paths_burst_in[p*40 +: 40] = (desc_q[p].size() != 0) ? desc_q[p][0] : 40'd0;
      paths_data_empty[p]     = (data_q[p].size() == 0) || stall[p];
      paths_data_in[p*DB +: DB] = (data_q[p].size() != 0) ? data_q[p][0] : 32'd0;
    end
    bvalid       = b_en && (b_q.size() != 0);
    {bid, bresp} = (b_q.size() != 0) ? b_q[0] : 6'd0;
  endfunction

  always @(negedge i_clk) refresh();

  // Monitor: samples pre-edge values of outputs and handshakes on every rising edge.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      for (int p = 0; p < P; p++) begin
        if (paths_burst_rd[p]) begin
          if (desc_q[p].size() == 0) chk("desc_pop_empty", 64'(p), 64'(99));
          else desc_q[p].delete(0);
        end
        if (paths_data_rd[p]) begin
          data_pops++;
          if (data_q[p].size() != 0) data_q[p].delete(0);
        end
      end
      if (paths_data_rd != '0 && !(wvalid && wready)) chk("stray_pop", 64'(paths_data_rd), 64'(0));
      if (awvalid && awready) begin
        aw_cnt++;
        if (exp_aw_q.size() == 0) chk("aw_extra", 64'({awid, awaddr, awlen}), 64'(0));
        else begin
          m_ae = exp_aw_q.pop_front();
          chk("aw", 64'({awid, awaddr, awlen}), 64'(m_ae));
        end
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (exp_w_q.size() == 0) chk("w_extra", 64'({wlast, wdata}), 64'(0));
        else begin
          m_we = exp_w_q.pop_front();
          chk("w_beat", 64'({wlast, wdata}), 64'(m_we[32:0]));
          chk("w_pop", 64'(paths_data_rd), 64'(2'b01 << m_we[36:33]));
          if (wlast && auto_b) b_q.push_back({m_we[36:33], 2'b00});
        end
      end
      if (bvalid && bready && b_q.size() != 0) b_q.delete(0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic load_burst(input int p, input logic [31:0] addr, input logic [7:0] beats);
    int n;
    logic [31:0] word;
    n = (beats == 8'd0) ? 256 : int'(beats);
    desc_q[p].push_back({addr, beats});
    exp_aw_q.push_back({4'(p), addr, beats - 8'd1});
    for (int i = 0; i < n; i++) begin
      word = {8'(p), 8'(seq), 16'(i)};
      data_q[p].push_back(word);
      exp_w_q.push_back({4'(p), (i == n - 1), word});
    end
    seq++;
    refresh();
  endtask

  task automatic push_b(input int id, input logic [1:0] resp);
    b_q.push_back({4'(id), resp});
    refresh();
  endtask

  task automatic reset_dut();
    i_rst = 1'b1;
    for (int p = 0; p < P; p++) begin
      desc_q[p].delete();
      data_q[p].delete();
    end
    exp_aw_q.delete();
    exp_w_q.delete();
    b_q.delete();
    stall = '0;
    i_err_clr = '0;
    refresh();
    repeat (2) tick();
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_done_err", 64'({o_done, o_err}), 64'(0));
    chk("rst_pops", 64'({paths_burst_rd, paths_data_rd}), 64'(0));
    chk("rst_outstanding", 64'(o_outstanding), 64'(0));
    i_rst = 1'b0;
  endtask

  task automatic wait_drain(input bit zero_out, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_aw_q.size() == 0 && exp_w_q.size() == 0 && b_q.size() == 0 &&
          (!zero_out || o_outstanding == 3'd0)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 64'(ok), 64'(1));
  endtask

  task automatic wait_awvalid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (awvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("awvalid_wait", 64'(ok), 64'(1));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base;
    bit ok;
    reset_dut();
    chk("awsize", 64'(awsize), 64'(2));
    chk("awburst", 64'(awburst), 64'(1));
    chk("awcache", 64'(awcache), 64'(3));
    chk("awproto", 64'(awproto), 64'(0));
    chk("wstrb", 64'(wstrb), 64'(4'hF));
    tick();
    chk("bready_up", 64'(bready), 64'(1));

    // single burst, 4 beats, B acknowledged by hand
    auto_b = 1'b0;
    base = data_pops;
    load_burst(0, 32'h0000_1000, 8'd4);
    wait_drain(1'b0, 40);
    chk("t1_pops", 64'(data_pops - base), 64'(4));
    chk("t1_out_before_b", 64'(o_outstanding), 64'(1));
    push_b(0, 2'b00);
    tick();
    chk("t1_done", 64'(o_done), 64'(2'b01));
    chk("t1_out_after_b", 64'(o_outstanding), 64'(0));
    tick();
    chk("t1_done_pulse", 64'(o_done), 64'(0));

    // round robin: path 0 has first priority after reset, then ids alternate
    reset_dut();
    auto_b = 1'b1;
    base = aw_cnt;
    load_burst(0, 32'h0000_2000, 8'd2);
    load_burst(1, 32'h0000_3000, 8'd2);
    load_burst(0, 32'h0000_2100, 8'd2);
    load_burst(1, 32'h0000_3100, 8'd2);
    load_burst(0, 32'h0000_2200, 8'd2);
    load_burst(1, 32'h0000_3200, 8'd2);
    wait_drain(1'b1, 200);
    chk("t2_aw_count", 64'(aw_cnt - base), 64'(6));

    // outstanding limit with B held off
    reset_dut();
    auto_b = 1'b1;
    b_en = 1'b0;
    refresh();
    base = aw_cnt;
    for (int i = 0; i < 6; i++) load_burst(0, 32'h0000_4000 + 32'(i * 256), 8'd1);
    repeat (30) tick();
    chk("t3_aw_limit", 64'(aw_cnt - base), 64'(4));
    chk("t3_awvalid_low", 64'(awvalid), 64'(0));
    chk("t3_out_full", 64'(o_outstanding), 64'(4));
    b_en = 1'b1;
    refresh();
    tick();
    b_en = 1'b0;
    refresh();
    repeat (10) tick();
    chk("t3_aw_release", 64'(aw_cnt - base), 64'(5));
    chk("t3_out_refull", 64'(o_outstanding), 64'(4));
    chk("t3_awvalid_low2", 64'(awvalid), 64'(0));
    b_en = 1'b1;
    reset_dut();

    // beats = 0 means a 256-beat burst
    auto_b = 1'b1;
    base = data_pops;
    load_burst(1, 32'h0000_5000, 8'd0);
    wait_drain(1'b1, 600);
    chk("t4_pops", 64'(data_pops - base), 64'(256));

    // AW held by awready, then W stalled by an empty data FIFO
    awready = 1'b0;
    load_burst(0, 32'h0000_6000, 8'd8);
    wait_awvalid(10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_aw_hold", 64'({awvalid, awaddr, awlen}), 64'({1'b1, 32'h0000_6000, 8'd7}));
    end
    awready = 1'b1;
    base = w_cnt;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (w_cnt - base == 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_w_start", 64'(ok), 64'(1));
    stall[0] = 1'b1;
    refresh();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_stall", 64'({wvalid, paths_data_rd}), 64'(0));
    end
    chk("t5_stall_beats", 64'(w_cnt - base), 64'(3));
    stall[0] = 1'b0;
    refresh();
    wait_drain(1'b1, 60);

    // error reporting, clear priority, shared AW/B cycle, out-of-range bid
    auto_b = 1'b0;
    load_burst(1, 32'h0000_7000, 8'd1);
    load_burst(1, 32'h0000_7100, 8'd1);
    wait_drain(1'b0, 50);
    chk("t6_out2", 64'(o_outstanding), 64'(2));
    push_b(1, 2'b10);
    tick();
    chk("t6_err_set", 64'(o_err), 64'(2'b10));
    chk("t6_done1", 64'(o_done), 64'(2'b10));
    chk("t6_out1", 64'(o_outstanding), 64'(1));
    tick();
    chk("t6_err_sticky", 64'(o_err), 64'(2'b10));
    chk("t6_done_clear", 64'(o_done), 64'(0));
    i_err_clr = 2'b10;
    tick();
    i_err_clr = 2'b00;
    chk("t6_err_cleared", 64'(o_err), 64'(0));
    push_b(1, 2'b10);
    i_err_clr = 2'b10;
    tick();
    i_err_clr = 2'b00;
    chk("t6_set_wins", 64'(o_err), 64'(2'b10));
    chk("t6_out0", 64'(o_outstanding), 64'(0));
    load_burst(0, 32'h0000_7200, 8'd1);
    wait_drain(1'b0, 50);
    chk("t6_out_one", 64'(o_outstanding), 64'(1));
    awready = 1'b0;
    load_burst(0, 32'h0000_7300, 8'd1);
    wait_awvalid(10);
    push_b(5, 2'b00);
    awready = 1'b1;
    tick();
    chk("t6_aw_b_same", 64'(o_outstanding), 64'(1));
    chk("t6_bid_oob_done", 64'(o_done), 64'(0));
    chk("t6_bid_oob_err", 64'(o_err), 64'(2'b10));
    wait_drain(1'b0, 50);
    push_b(0, 2'b00);
    tick();
    chk("t6_final_out", 64'(o_outstanding), 64'(0));
    chk("t6_final_done", 64'(o_done), 64'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
